// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// The register geometry comes from the core-wide RegCnt/RegWidth macros.
// If those macros are absent, this file falls back to a 32 x 32-bit register file.
`ifndef RegCnt
`define RegCnt 5
`endif
`ifndef RegWidth
`define RegWidth 32
`endif

package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = `RegCnt;
  localparam int REG_DATA_W = `RegWidth;
  localparam int SB_CNT_W   = 2;

  // Writeback source identifiers; also used as the round-robin history bit.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // Per-register in-flight write counter at the default width.
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register.
// Decode increments a counter on issue, and the registered regfile write decrements it.
// A source operand is busy while its counter is non-zero.
// Register x0 is never tracked.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int CNT_W      = SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_rd
);

  localparam int              NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             iss_fire;

  // Issue is refused only when the destination counter would overflow.
  assign iss_ready = (iss_rd == '0) || (cnt_q[iss_rd] != CNT_MAX);
  assign iss_fire  = iss_valid && iss_ready;
  assign rs1_busy  = (rs1 != '0) && (cnt_q[rs1] != '0);
  assign rs2_busy  = (rs2 != '0) && (cnt_q[rs2] != '0);

  // Next counter values.
  // A simultaneous issue and writeback to the same register cancel out.
  // A counter already at zero is never decremented.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (iss_fire && (iss_rd == ADDR_WIDTH'(r)) &&
                   !(wb_wen && (wb_rd == ADDR_WIDTH'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wb_wen && (wb_rd == ADDR_WIDTH'(r)) &&
                   !(iss_fire && (iss_rd == ADDR_WIDTH'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Counter registers; reset forgets every in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  wb_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_wen && (wb_rd != '0)) |-> (cnt_q[wb_rd] != '0));
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter.
// Round-robin merges the ALU and LSU results into the single regfile write port.
// It registers the write and keeps the RAW-hazard scoreboard for decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int CNT_W      = SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  wb_src_e               last_grant_q, last_grant_d;
  logic                  grant_alu, grant_lsu;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  // Round-robin grant: on a tie, the source not granted last time wins.
  always_comb begin
    grant_alu    = 1'b0;
    grant_lsu    = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_valid && lsu_valid) begin
      if (last_grant_q == WB_SRC_ALU) begin
        grant_lsu = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else if (alu_valid) begin
      grant_alu = 1'b1;
    end else if (lsu_valid) begin
      grant_lsu = 1'b1;
    end
    if (grant_alu) begin
      last_grant_d = WB_SRC_ALU;
    end else if (grant_lsu) begin
      last_grant_d = WB_SRC_LSU;
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  // Capture the granted result for next cycle.
  // An x0 result is consumed without touching the port.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_alu && (alu_rd != '0)) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end else if (grant_lsu && (lsu_rd != '0)) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = lsu_rd;
      rf_wdata_d = lsu_data;
    end
  end

  // Output and arbitration-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= WB_SRC_ALU;
      rf_wen_q     <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_W     (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .wb_wen   (rf_wen_q),
    .wb_rd    (rf_rd_q)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// It runs directed scenarios, then randomized producers and issue traffic.
// Everything is compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_ready;
  logic [AW-1:0] rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;

  // Free-running clock.
  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .lsu_valid(lsu_valid),
    .lsu_rd   (lsu_rd),
    .lsu_data (lsu_data),
    .lsu_ready(lsu_ready),
    .rf_wen   (rf_wen),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_cnt [NREG];
  bit            m_last_lsu;
  bit            m_wen;
  int            m_rd;
  logic [DW-1:0] m_wdata;
  bit            m_data_known;
  bit            seen_alu_ready, seen_lsu_ready, seen_iss_ready;
  bit            seen_rs1_busy, seen_rs2_busy;
  int            outstanding [$];

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state after reset.
  task automatic modelReset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last_lsu   = 1'b0;
    m_wen        = 1'b0;
    m_rd         = 0;
    m_wdata      = '0;
    m_data_known = 1'b1;
    outstanding.delete();
  endtask

  // Drop all stimulus inputs to idle.
  task automatic idle();
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  // Runs one clock cycle with the inputs currently driven.
  // It checks the combinational outputs shortly after the inputs settle.
  // It advances the model and checks the registered outputs at the next falling edge.
  task automatic applyStimulus();
    bit            g_alu, g_lsu, e_iss_ready;
    int            wrd;
    logic [DW-1:0] wdat;
    #1;
    g_alu       = alu_valid && (!lsu_valid || m_last_lsu);
    g_lsu       = lsu_valid && (!alu_valid || !m_last_lsu);
    e_iss_ready = (iss_rd == 0) || (m_cnt[iss_rd] < CMAX);
    checkOutput("alu_ready", alu_ready, g_alu);
    checkOutput("lsu_ready", lsu_ready, g_lsu);
    checkOutput("iss_ready", iss_ready, e_iss_ready);
    checkOutput("rs1_busy", rs1_busy, (rs1 != 0) && (m_cnt[rs1] > 0));
    checkOutput("rs2_busy", rs2_busy, (rs2 != 0) && (m_cnt[rs2] > 0));
    seen_alu_ready = alu_ready;
    seen_lsu_ready = lsu_ready;
    seen_iss_ready = iss_ready;
    seen_rs1_busy  = rs1_busy;
    seen_rs2_busy  = rs2_busy;
    if (iss_valid && e_iss_ready && iss_rd != 0) m_cnt[iss_rd]++;
    if (m_wen && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
    if (g_alu || g_lsu) begin
      wrd        = g_alu ? int'(alu_rd) : int'(lsu_rd);
      wdat       = g_alu ? alu_data : lsu_data;
      m_last_lsu = g_lsu;
      if (wrd != 0) begin
        m_wen        = 1'b1;
        m_rd         = wrd;
        m_wdata      = wdat;
        m_data_known = 1'b1;
      end else begin
        m_wen        = 1'b0;
        m_data_known = 1'b0;
      end
    end else begin
      m_wen = 1'b0;
    end
    @(negedge clk);
    checkOutput("rf_wen", rf_wen, m_wen);
    if (m_data_known) begin
      checkOutput("rf_rd", rf_rd, m_rd);
      checkOutput("rf_wdata", rf_wdata, m_wdata);
    end
  endtask

  // Asynchronous reset, asserted at a falling edge and held for one cycle.
  task automatic doReset();
    rst_n = 1'b0;
    idle();
    #1;
    checkOutput("reset_rf_wen", rf_wen, 0);
    checkOutput("reset_rs1_busy", rs1_busy, 0);
    checkOutput("reset_rs2_busy", rs2_busy, 0);
    modelReset();
    @(negedge clk);
    checkOutput("reset_rf_rd", rf_rd, 0);
    checkOutput("reset_rf_wdata", rf_wdata, 0);
    rst_n = 1'b1;
  endtask

  // A new producer result: usually a pending destination, sometimes x0.
  task automatic pickResult(output logic [AW-1:0] rd, output logic [DW-1:0] d);
    int idx;
    if (outstanding.size() > 0 && $urandom_range(0, 7) != 0) begin
      idx = $urandom_range(0, outstanding.size() - 1);
      rd  = AW'(outstanding[idx]);
      outstanding.delete(idx);
    end else begin
      rd = '0;
    end
    d = $urandom;
  endtask

  // Main sequence: directed scenarios first, then random traffic.
  initial begin
    rst_n = 1'b0;
    idle();
    iss_rd = '0; rs1 = '0; rs2 = '0;
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
    modelReset();
    @(negedge clk);
    checkOutput("init_rf_wen", rf_wen, 0);
    checkOutput("init_rf_rd", rf_rd, 0);
    checkOutput("init_rf_wdata", rf_wdata, 0);
    rst_n = 1'b1;

    // ALU-only writeback to x5.
    idle(); iss_valid = 1'b1; iss_rd = 5; applyStimulus();
    idle(); alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h1234; applyStimulus();
    checkOutput("alu_only_ready", seen_alu_ready, 1);
    checkOutput("alu_only_wen", rf_wen, 1);
    checkOutput("alu_only_rd", rf_rd, 5);
    checkOutput("alu_only_wdata", rf_wdata, 32'h1234);
    idle(); applyStimulus();

    // Tie for four cycles: grants must alternate LSU, ALU, LSU, ALU.
    idle(); iss_valid = 1'b1;
    iss_rd = 3; applyStimulus();
    iss_rd = 4; applyStimulus();
    iss_rd = 3; applyStimulus();
    iss_rd = 4; applyStimulus();
    idle();
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'hA000_0000;
    lsu_valid = 1'b1; lsu_rd = 4; lsu_data = 32'hB000_0000;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("tie_lsu_grant", seen_lsu_ready, (k % 2 == 0));
      checkOutput("tie_rf_rd", rf_rd, (k % 2 == 0) ? 4 : 3);
      if (seen_alu_ready) alu_data = alu_data + 1;
      if (seen_lsu_ready) lsu_data = lsu_data + 1;
    end
    idle(); applyStimulus(); applyStimulus();

    // Scoreboard: two writes pending on x7.
    idle(); rs1 = 7; iss_valid = 1'b1; iss_rd = 7; applyStimulus(); applyStimulus();
    idle(); applyStimulus();
    checkOutput("sb_busy_pending", seen_rs1_busy, 1);
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h7; applyStimulus();
    alu_data = 32'h77; applyStimulus();
    idle(); applyStimulus();
    checkOutput("sb_busy_during_last_wen", seen_rs1_busy, 1);
    applyStimulus();
    checkOutput("sb_busy_cleared", seen_rs1_busy, 0);

    // Saturation of x9's counter.
    idle(); rs2 = 9; iss_valid = 1'b1; iss_rd = 9;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("sat_iss_ready", seen_iss_ready, (k < 3));
    end
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h99; applyStimulus();
    checkOutput("sat_still_full", seen_iss_ready, 0);
    idle(); iss_rd = 9; applyStimulus();
    applyStimulus();
    checkOutput("sat_ready_after_wb", seen_iss_ready, 1);
    alu_valid = 1'b1; applyStimulus(); applyStimulus();
    idle(); applyStimulus(); applyStimulus();
    checkOutput("sat_drained", seen_rs2_busy, 0);

    // An x0 result is consumed but never written.
    idle(); alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h55; applyStimulus();
    checkOutput("x0_ready", seen_alu_ready, 1);
    checkOutput("x0_no_wen", rf_wen, 0);

    // An issue to x2 in the same cycle as rf_wen to x2 leaves the count unchanged.
    idle(); rs1 = 2; iss_valid = 1'b1; iss_rd = 2; applyStimulus();
    idle(); alu_valid = 1'b1; alu_rd = 2; alu_data = 32'h22; applyStimulus();
    idle(); iss_valid = 1'b1; iss_rd = 2; applyStimulus();
    idle(); applyStimulus();
    checkOutput("same_cycle_busy", seen_rs1_busy, 1);
    alu_valid = 1'b1; applyStimulus();
    idle(); applyStimulus(); applyStimulus();
    checkOutput("same_cycle_cleared", seen_rs1_busy, 0);

    // Reset while a write to x11 is on the port.
    idle(); rs1 = 11; iss_valid = 1'b1; iss_rd = 11; applyStimulus(); applyStimulus();
    idle(); alu_valid = 1'b1; alu_rd = 11; alu_data = 32'hBEEF; applyStimulus();
    checkOutput("pre_reset_wen", rf_wen, 1);
    doReset();

    // The first tie after reset goes to the LSU.
    alu_valid = 1'b1; alu_rd = 0; lsu_valid = 1'b1; lsu_rd = 0; applyStimulus();
    checkOutput("post_reset_tie_lsu", seen_lsu_ready, 1);
    checkOutput("post_reset_tie_alu", seen_alu_ready, 0);
    idle(); applyStimulus();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      if (!alu_valid && $urandom_range(0, 2) == 0) begin
        pickResult(alu_rd, alu_data);
        alu_valid = 1'b1;
      end
      if (!lsu_valid && $urandom_range(0, 2) == 0) begin
        pickResult(lsu_rd, lsu_data);
        lsu_valid = 1'b1;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom_range(0, 10));
      rs1       = AW'($urandom_range(0, 10));
      rs2       = AW'($urandom_range(0, 10));
      applyStimulus();
      if (iss_valid && seen_iss_ready && iss_rd != 0) outstanding.push_back(int'(iss_rd));
      if (seen_alu_ready) alu_valid = 1'b0;
      if (seen_lsu_ready) lsu_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
